// File: rtl/apb_timer_pkg.sv
// Shared encodings for the APB timer register file: register offsets, FSM states, status/enable bit indices.
package apb_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam logic [1:0] OFF_TDR = 2'd0;
  localparam logic [1:0] OFF_TCR = 2'd1;
  localparam logic [1:0] OFF_TSR = 2'd2;

  localparam int unsigned TSR_OVF   = 0;
  localparam int unsigned TSR_UDF   = 1;
  localparam int unsigned TCR_OVFIE = 4;
  localparam int unsigned TCR_UDFIE = 5;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/apb_timer_regfile_if.sv
// APB3 bus bundle between the interconnect (master) and the timer register file (slave).
interface apb_timer_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/timer_ch_regs.sv
// One timer channel: TDR/TCR storage, sticky W1C status with set priority, and the TDR reload strobe.
module timer_ch_regs
  import apb_timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  wr_tdr,
  input  logic                  wr_tcr,
  input  logic                  wr_tsr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ovf_set,
  input  logic                  udf_set,
  output logic [DATA_WIDTH-1:0] tdr,
  output logic [DATA_WIDTH-1:0] tcr,
  output logic                  ovf,
  output logic                  udf,
  output logic                  tdr_wr
);

  // An event pulse in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tdr    <= '0;
      tcr    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      tdr_wr <= 1'b0;
    end else begin
      if (wr_tdr) tdr <= wdata;
      if (wr_tcr) tcr <= wdata;
      tdr_wr <= wr_tdr;
      ovf    <= ovf_set | (ovf & ~(wr_tsr & wdata[TSR_OVF]));
      udf    <= udf_set | (udf & ~(wr_tsr & wdata[TSR_UDF]));
    end
  end

endmodule

// File: rtl/apb_timer_regfile.sv
// APB3 register file for NUM_CH timer channels with wait states and decode errors.
// Optional TIMER_IRQ_EN adds a registered irq output gated by TCR interrupt-enable bits.
module apb_timer_regfile
  import apb_timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  apb_timer_regfile_if.slave           apb,
  input  logic [NUM_CH-1:0]            ovf_set,
  input  logic [NUM_CH-1:0]            udf_set,
  output logic [NUM_CH*DATA_WIDTH-1:0] tdr_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] tcr_o,
  output logic [NUM_CH-1:0]            tdr_wr
`ifdef TIMER_IRQ_EN
  ,
  output logic                         irq
`endif
);

  localparam int unsigned CH_W = ADDR_WIDTH - 2;

  apb_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic [CH_W-1:0]       ch;
  logic [1:0]            off;
  logic                  dec_err;
  logic                  ready_c;
  logic                  commit_c;
  logic [NUM_CH-1:0]     ovf_q;
  logic [NUM_CH-1:0]     udf_q;
  logic [DATA_WIDTH-1:0] rdata_c;

  assign ch       = apb.PADDR[ADDR_WIDTH-1:2];
  assign off      = apb.PADDR[1:0];
  assign dec_err  = (32'(ch) >= 32'(NUM_CH)) || (off == 2'd3);
  assign ready_c  = (state == ACCESS) && (cnt == CNT_W'(WAIT_STATES));
  assign commit_c = apb.PSEL & apb.PENABLE & ready_c & apb.PWRITE & ~dec_err;

  assign apb.PREADY  = ready_c;
  assign apb.PSLVERR = ready_c & dec_err;
  assign apb.PRDATA  = rdata_c;

  // Transfer sequencer; dropping PSEL abandons the transfer from any state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!apb.PSEL) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!apb.PENABLE) state <= SETUP;
        SETUP: begin
          state <= ACCESS;
          cnt   <= '0;
        end
        ACCESS: begin
          if (ready_c) state <= IDLE;
          else         cnt   <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic sel_c;
    assign sel_c = commit_c && (ch == CH_W'(n));

    timer_ch_regs #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .wr_tdr  (sel_c && (off == OFF_TDR)),
      .wr_tcr  (sel_c && (off == OFF_TCR)),
      .wr_tsr  (sel_c && (off == OFF_TSR)),
      .wdata   (apb.PWDATA),
      .ovf_set (ovf_set[n]),
      .udf_set (udf_set[n]),
      .tdr     (tdr_o[n*DATA_WIDTH +: DATA_WIDTH]),
      .tcr     (tcr_o[n*DATA_WIDTH +: DATA_WIDTH]),
      .ovf     (ovf_q[n]),
      .udf     (udf_q[n]),
      .tdr_wr  (tdr_wr[n])
    );
  end

  // Read data is only presented in the completing cycle of a decodable access.
  always_comb begin
    rdata_c = '0;
    if (ready_c && !dec_err) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch == CH_W'(n)) begin
          case (off)
            OFF_TDR: rdata_c = tdr_o[n*DATA_WIDTH +: DATA_WIDTH];
            OFF_TCR: rdata_c = tcr_o[n*DATA_WIDTH +: DATA_WIDTH];
            OFF_TSR: begin
              rdata_c[TSR_OVF] = ovf_q[n];
              rdata_c[TSR_UDF] = udf_q[n];
            end
            default: rdata_c = '0;
          endcase
        end
      end
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_c;

  always_comb begin
    irq_c = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      irq_c = irq_c
            | (ovf_q[n] & tcr_o[n*DATA_WIDTH + TCR_OVFIE])
            | (udf_q[n] & tcr_o[n*DATA_WIDTH + TCR_UDFIE]);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) irq <= 1'b0;
    else          irq <= irq_c;
  end
`endif

endmodule

// File: tb/tb_apb_timer_regfile.sv
// Directed bench for apb_timer_regfile: one instance with no wait states, one with three.
module tb_apb_timer_regfile;

  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  apb_timer_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();
  apb_timer_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();

  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic       pready  [2];
  logic       pslverr [2];
  logic [7:0] prdata  [2];
  logic [1:0] ovf     [2];
  logic [1:0] udf     [2];

  logic [15:0] tdr0, tcr0, tdr1, tcr1;
  logic [1:0]  tdr_wr0, tdr_wr1;
`ifdef TIMER_IRQ_EN
  logic        irq0, irq1;
`endif

  assign bus0.PSEL    = psel[0];
  assign bus0.PENABLE = penable[0];
  assign bus0.PWRITE  = pwrite[0];
  assign bus0.PADDR   = paddr[0];
  assign bus0.PWDATA  = pwdata[0];
  assign pready[0]    = bus0.PREADY;
  assign pslverr[0]   = bus0.PSLVERR;
  assign prdata[0]    = bus0.PRDATA;

  assign bus1.PSEL    = psel[1];
  assign bus1.PENABLE = penable[1];
  assign bus1.PWRITE  = pwrite[1];
  assign bus1.PADDR   = paddr[1];
  assign bus1.PWDATA  = pwdata[1];
  assign pready[1]    = bus1.PREADY;
  assign pslverr[1]   = bus1.PSLVERR;
  assign prdata[1]    = bus1.PRDATA;

  apb_timer_regfile #(.DATA_WIDTH(8), .NUM_CH(2), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus0),
    .ovf_set (ovf[0]),
    .udf_set (udf[0]),
    .tdr_o   (tdr0),
    .tcr_o   (tcr0),
    .tdr_wr  (tdr_wr0)
`ifdef TIMER_IRQ_EN
    ,
    .irq     (irq0)
`endif
  );

  apb_timer_regfile #(.DATA_WIDTH(8), .NUM_CH(2), .ADDR_WIDTH(8), .WAIT_STATES(3)) u_dut1 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus1),
    .ovf_set (ovf[1]),
    .udf_set (udf[1]),
    .tdr_o   (tdr1),
    .tcr_o   (tcr1),
    .tdr_wr  (tdr_wr1)
`ifdef TIMER_IRQ_EN
    ,
    .irq     (irq1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns at the cycle after the completing edge with PSEL dropped.
  task automatic xfer(input int b, input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                      input logic [1:0] ovf_commit, output logic [7:0] rd, output logic err,
                      output int waits, output logic early);
    @(posedge PCLK); #1;
    psel[b] = 1'b1; penable[b] = 1'b0; pwrite[b] = wr; paddr[b] = addr; pwdata[b] = wd;
    @(posedge PCLK); #1;
    penable[b] = 1'b1;
    waits = 0;
    early = 1'b0;
    while (pready[b] !== 1'b1 && waits < 20) begin
      if (prdata[b] !== 8'h00) early = 1'b1;
      @(posedge PCLK); #1;
      waits++;
    end
    rd  = prdata[b];
    err = pslverr[b];
    ovf[b] = ovf[b] | ovf_commit;
    @(posedge PCLK); #1;
    psel[b] = 1'b0; penable[b] = 1'b0;
    ovf[b] = ovf[b] & ~ovf_commit;
  endtask

  task automatic wr_ok(input int b, input logic [7:0] addr, input logic [7:0] wd, input logic [1:0] oc);
    logic [7:0] rd; logic err; int w; logic e;
    xfer(b, 1'b1, addr, wd, oc, rd, err, w, e);
    check("wr_slverr", 32'(err), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input int b, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] rd; logic err; int w; logic e;
    xfer(b, 1'b0, addr, 8'h00, 2'b00, rd, err, w, e);
    check(tag, 32'(rd), 32'(exp));
    check({tag, "_slverr"}, 32'(err), 32'd0);
  endtask

  task automatic pulse(input int b, input logic [1:0] o, input logic [1:0] u);
    @(posedge PCLK); #1;
    ovf[b] = o; udf[b] = u;
    @(posedge PCLK); #1;
    ovf[b] = 2'b00; udf[b] = 2'b00;
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         w;
    logic       early;

    for (int b = 0; b < 2; b++) begin
      psel[b] = 1'b0; penable[b] = 1'b0; pwrite[b] = 1'b0;
      paddr[b] = 8'h00; pwdata[b] = 8'h00; ovf[b] = 2'b00; udf[b] = 2'b00;
    end
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", 32'(pready[0]), 32'd0);
    check("rst_prdata", 32'(prdata[0]), 32'd0);
    check("rst_pslverr", 32'(pslverr[0]), 32'd0);
    check("rst_tdr", 32'({tdr0, tdr1}), 32'd0);
    check("rst_tcr", 32'({tcr0, tcr1}), 32'd0);
    check("rst_tdr_wr", 32'({tdr_wr0, tdr_wr1}), 32'd0);
`ifdef TIMER_IRQ_EN
    check("rst_irq", 32'({irq0, irq1}), 32'd0);
`endif
    PRESETn = 1'b1;

    // ch1 TDR write, zero wait states
    xfer(0, 1'b1, 8'h04, 8'hA5, 2'b00, rd, err, w, early);
    check("ws0_waits", 32'(w), 32'd1);
    check("ws0_slverr", 32'(err), 32'd0);
    check("tdr_wr_pulse", 32'(tdr_wr0), 32'h2);
    check("tdr_o_ch1", 32'(tdr0), 32'h0000_A500);
    @(posedge PCLK); #1;
    check("tdr_wr_clear", 32'(tdr_wr0), 32'h0);
    rd_chk("rd_tdr1", 0, 8'h04, 8'hA5);

    wr_ok(0, 8'h01, 8'h3C, 2'b00);
    check("tdr_wr_tcr_none", 32'(tdr_wr0), 32'h0);
    check("tcr_o_ch0", 32'(tcr0), 32'h0000_003C);
    rd_chk("rd_tcr0", 0, 8'h01, 8'h3C);

    // three wait states
    wr_ok(1, 8'h01, 8'h5A, 2'b00);
    check("tcr1_o", 32'(tcr1), 32'h0000_005A);
    xfer(1, 1'b0, 8'h01, 8'h00, 2'b00, rd, err, w, early);
    check("ws3_waits", 32'(w), 32'd4);
    check("ws3_rdata", 32'(rd), 32'h5A);
    check("ws3_early_prdata", 32'(early), 32'd0);
    check("ws3_tdr_wr", 32'(tdr_wr1), 32'd0);

    // sticky status and write-1-to-clear
    pulse(0, 2'b01, 2'b00);
    rd_chk("tsr_ovf_set", 0, 8'h02, 8'h01);
    wr_ok(0, 8'h02, 8'h00, 2'b00);
    rd_chk("tsr_w0_noeff", 0, 8'h02, 8'h01);
    wr_ok(0, 8'h02, 8'h01, 2'b00);
    rd_chk("tsr_w1c", 0, 8'h02, 8'h00);
    wr_ok(0, 8'h02, 8'h01, 2'b01);
    rd_chk("tsr_set_wins", 0, 8'h02, 8'h01);
    wr_ok(0, 8'h02, 8'h01, 2'b00);
    rd_chk("tsr_clr2", 0, 8'h02, 8'h00);

    // simultaneous events across channels
    pulse(0, 2'b10, 2'b11);
    pulse(0, 2'b10, 2'b00);
    rd_chk("tsr1_both", 0, 8'h06, 8'h03);
    rd_chk("tsr0_udf", 0, 8'h02, 8'h02);
    wr_ok(0, 8'h02, 8'hFF, 2'b00);
    rd_chk("tsr0_clr_all", 0, 8'h02, 8'h00);
    wr_ok(0, 8'h06, 8'h02, 2'b00);
    rd_chk("tsr1_udf_only_clr", 0, 8'h06, 8'h01);
    wr_ok(0, 8'h06, 8'h01, 2'b00);
    rd_chk("tsr1_clr", 0, 8'h06, 8'h00);

    // decode errors
    xfer(0, 1'b1, 8'h03, 8'hFF, 2'b00, rd, err, w, early);
    check("err_wr_rsvd", 32'(err), 32'd1);
    xfer(0, 1'b1, 8'h08, 8'hEE, 2'b00, rd, err, w, early);
    check("err_wr_ch2", 32'(err), 32'd1);
    check("err_wr_no_strobe", 32'(tdr_wr0), 32'd0);
    check("err_wr_tdr_kept", 32'(tdr0), 32'h0000_A500);
    check("err_wr_tcr_kept", 32'(tcr0), 32'h0000_003C);
    xfer(0, 1'b0, 8'h03, 8'h00, 2'b00, rd, err, w, early);
    check("err_rd_rsvd_err", 32'(err), 32'd1);
    check("err_rd_rsvd_data", 32'(rd), 32'd0);
    xfer(0, 1'b0, 8'h08, 8'h00, 2'b00, rd, err, w, early);
    check("err_rd_ch2_err", 32'(err), 32'd1);
    check("err_rd_ch2_data", 32'(rd), 32'd0);
    xfer(0, 1'b0, 8'h07, 8'h00, 2'b00, rd, err, w, early);
    check("err_rd_ch1_rsvd", 32'({err, rd}), 32'h100);
    rd_chk("tsr0_after_err", 0, 8'h02, 8'h00);

    // transfer abandoned in SETUP
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h01; pwdata[0] = 8'h77;
    @(posedge PCLK); #1;
    check("abandon_in_setup", 32'(u_dut0.state), 32'd1);
    psel[0] = 1'b0;
    @(posedge PCLK); #1;
    check("abandon_idle", 32'(u_dut0.state), 32'd0);
    check("abandon_tcr", 32'(tcr0), 32'h0000_003C);
    rd_chk("abandon_rd_tcr", 0, 8'h01, 8'h3C);

`ifdef TIMER_IRQ_EN
    wr_ok(0, 8'h01, 8'h10, 2'b00);
    pulse(0, 2'b01, 2'b00);
    check("irq_lag", 32'(irq0), 32'd0);
    @(posedge PCLK); #1;
    check("irq_set", 32'(irq0), 32'd1);
    wr_ok(0, 8'h02, 8'h01, 2'b00);
    check("irq_hold_after_w1c", 32'(irq0), 32'd1);
    @(posedge PCLK); #1;
    check("irq_clear", 32'(irq0), 32'd0);
    pulse(0, 2'b00, 2'b01);
    @(posedge PCLK); #1;
    check("irq_udf_masked", 32'(irq0), 32'd0);
    wr_ok(0, 8'h02, 8'h02, 2'b00);
    wr_ok(0, 8'h01, 8'h3C, 2'b00);
`endif

    // reset in the completing ACCESS cycle
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h04;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    @(posedge PCLK); #1;
    check("pre_rst_prdata", 32'(prdata[0]), 32'hA5);
    PRESETn = 1'b0;
    #1;
    check("midrst_pready", 32'(pready[0]), 32'd0);
    check("midrst_prdata", 32'(prdata[0]), 32'd0);
    check("midrst_pslverr", 32'(pslverr[0]), 32'd0);
    check("midrst_tdr", 32'({tdr0, tdr1}), 32'd0);
    check("midrst_tcr", 32'({tcr0, tcr1}), 32'd0);
    ovf[0] = 2'b11; udf[0] = 2'b11;
    @(posedge PCLK);
    @(posedge PCLK); #1;
    ovf[0] = 2'b00; udf[0] = 2'b00;
    psel[0] = 1'b0; penable[0] = 1'b0;
    PRESETn = 1'b1;
    rd_chk("post_rst_tsr0", 0, 8'h02, 8'h00);
    rd_chk("post_rst_tsr1", 0, 8'h06, 8'h00);
    rd_chk("post_rst_tdr1", 0, 8'h04, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
